pin_scan_sequencer: RTL
=======================

Name: pin_scan_sequencer

Overview:
- Sequences the pin-scan blink code across every candidate pin of the board, one pin at a time.
- For each pin it emits the pulse-coded frame PREAMBLE, COL pulses, PAUSE, ROW pulses, GAP on code_out. It presents the pin index so a top-level mux can route code_out to exactly that pin.
- Sits between the board pin mux and a start/loop control (button or soft register). Turns the blink encoder into a full-board scan with a start/busy/done handshake.

Parameters:
- NUM_PINS, 64, number of pins scanned (>=1).
- COLS, 8, columns per row in the index-to-(col,row) map; power of two.
- HALF, 16, clock cycles per half slot; slot = 2*HALF cycles (>=1).
- PRE_SLOTS, 2, preamble length in slots (code_out held high).
- PAUSE_SLOTS, 3, low slots between the COL and ROW fields.
- GAP_SLOTS, 4, low slots after ROW before the next pin.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a scan; sampled only in IDLE.
- loop  in  1  level; when 1, the scan wraps to pin 0 instead of stopping.
- stop  in  1  pulse; ends the scan at the next pin boundary.
- pin_idx  out  clog2(NUM_PINS) (min 1)  pin currently being coded.
- pin_en  out  1  high while pin_idx is valid (state != IDLE).
- code_out  out  1  serial blink code for the selected pin.
- field  out  3  current state encoding (debug/LED).
- busy  out  1  high while not IDLE.
- done  out  1  single-cycle pulse at end of each full scan.

Behaviour:
- Reset: state=IDLE, pin_idx=0, pin_en=0, code_out=0, busy=0, done=0, stop latch=0, all counters=0. Reset mid-frame aborts immediately, and the next cycle is IDLE.
- Mapping: col = (pin_idx mod COLS)+1, row = (pin_idx div COLS)+1. Both are computed from pin_idx and held stable for the whole frame. Width must be sized so row = NUM_PINS/COLS+1 does not overflow.
- Slot timer: cycle counter 0..2*HALF-1. Phase is "high half" for counts 0..HALF-1. slot_end fires on count 2*HALF-1. The timer restarts at 0 on every state entry.
- States:
  - IDLE -> PRE on start (registered, 1-cycle latency): pin_idx=0, busy=1.
  - PRE: code_out=1 for PRE_SLOTS full slots.
  - COL: col slots; code_out = high-half phase.
  - PAUSE: code_out=0 for PAUSE_SLOTS slots.
  - ROW: row slots, same pulse shape as COL.
  - GAP: code_out=0 for GAP_SLOTS slots. At the end of GAP:
    - if pin_idx < NUM_PINS-1 and no stop latched: pin_idx+1 -> PRE.
    - else if pin_idx = NUM_PINS-1: done=1 for that cycle; if loop=1 and no stop latched, pin_idx=0 -> PRE, else -> IDLE.
    - else (stop latched, not last pin) -> IDLE without done.
- Slot counter per field compares against the field length and resets to 0 on every field transition.
- Zero-length fields (PAUSE_SLOTS=0 or GAP_SLOTS=0) are skipped with no idle cycle.
- stop: latched while busy and cleared on entering IDLE or on reset. It never truncates a frame in progress.
- start while busy is ignored. start and stop asserted together in IDLE: start wins, and stop is ignored in that cycle.
- code_out is registered and is 0 whenever state=IDLE. pin_en equals busy.
- Frame length in slots = PRE_SLOTS+col+PAUSE_SLOTS+row+GAP_SLOTS.

Decomposition:
- Package pin_scan_pkg:
  - state enum (IDLE, PRE, COL, PAUSE, ROW, GAP) with a fixed 3-bit encoding that is exported on field.
  - default parameter constants.
  - function computing frame length in slots, used by the bench.
- One sub-module, scan_slot_timer. Inputs: clk, reset, restart. Outputs: high_phase, slot_end. Parameterised by HALF. The FSM, counters and mapping stay in the top module.

Test Plan (NUM_PINS=4, COLS=2, HALF=2, PRE_SLOTS=2, PAUSE_SLOTS=1, GAP_SLOTS=2; slot=4 cycles):
- Single scan: 1-cycle start pulse with loop=0 -> busy high for exactly 128 cycles. Frames are 7/8/8/9 slots for pins 0..3. done is high in the final GAP cycle only, and busy=0 on the next cycle.
- Pin 3 waveform: code_out = 8 high; 1010 pattern as 2 high/2 low ×2 (COL); 4 low; 2 high/2 low ×2 (ROW); 8 low. pin_idx=3 throughout.
- Loop: loop=1, start -> pin_idx sequence 0,1,2,3,0 with no IDLE gap. done pulses once every 128 cycles.
- Stop: stop pulse during pin 1's COL field -> pin 1 frame completes (8 slots), then IDLE, pin_en=0, and no done pulse.
- Reset mid-frame: reset during pin 2 ROW -> next cycle state=IDLE, code_out=0, pin_idx=0, busy=0. A subsequent start restarts at pin 0.
- Start ignored while busy: extra start pulses during the scan -> same 128-cycle timing as the single scan. Start and stop together in IDLE -> scan starts.

Source files
------------

// File: rtl/pin_scan_pkg.sv
// pin_scan_pkg
// Shared definitions for the pin-scan sequencer: the frame state encoding
// (exported as-is on the 'field' debug output), default parameter values,
// and helpers for sizing and frame-length arithmetic.
package pin_scan_pkg;

  // Fixed encoding so LEDs / logic analysers can decode 'field' directly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_COL   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ROW   = 3'd4,
    ST_GAP   = 3'd5
  } scan_state_t;

  localparam int DEF_NUM_PINS    = 64;
  localparam int DEF_COLS        = 8;
  localparam int DEF_HALF        = 16;
  localparam int DEF_PRE_SLOTS   = 2;
  localparam int DEF_PAUSE_SLOTS = 3;
  localparam int DEF_GAP_SLOTS   = 4;

  // Total slots spent on one pin's frame.
  function automatic int frame_slots(input int pre, input int col, input int pause,
                                     input int row, input int gap);
    return pre + col + pause + row + gap;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pin_scan_sequencer_slot_timer.sv
// scan_slot_timer
// Free-running slot timer: counts 0..2*HALF-1 and wraps. The first HALF
// counts of a slot are the "high" half.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   restart     - hold the count at 0 (next cycle starts a fresh slot)
//   high_phase  - phase of the NEXT cycle's count, so a consumer that
//                 registers it lines up exactly with the slot it belongs to
//   slot_end    - current cycle is the last cycle of a slot
module scan_slot_timer #(
  parameter int HALF = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic high_phase,
  output logic slot_end
);

  localparam int CW = $clog2(2 * HALF);

  logic [CW-1:0] cnt;

  assign slot_end = (cnt == CW'(2 * HALF - 1));

  // After a restart or a wrap the next count is 0, which is always high.
  assign high_phase = restart || slot_end || ((int'(cnt) + 1) < HALF);

  // Count up, wrapping at the end of each slot; restart pins it to 0.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pin_scan_sequencer.sv
// pin_scan_sequencer
// Walks every board pin in turn and emits the blink frame
// PREAMBLE, COL pulses, PAUSE, ROW pulses, GAP on code_out, while presenting
// the pin index so a board-level mux can route code_out to that pin.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - begin a scan (only looked at while idle)
//   loop        - level; wrap to pin 0 after the last pin instead of stopping
//   stop        - pulse; finish the current pin's frame, then go idle
//   pin_idx     - pin currently being coded
//   pin_en      - pin_idx is valid (same as busy)
//   code_out    - serial blink code
//   field       - current state encoding (debug)
//   busy        - scan in progress
//   done        - one-cycle pulse on the last cycle of a full scan
module pin_scan_sequencer
  import pin_scan_pkg::*;
#(
  parameter int NUM_PINS    = DEF_NUM_PINS,
  parameter int COLS        = DEF_COLS,
  parameter int HALF        = DEF_HALF,
  parameter int PRE_SLOTS   = DEF_PRE_SLOTS,
  parameter int PAUSE_SLOTS = DEF_PAUSE_SLOTS,
  parameter int GAP_SLOTS   = DEF_GAP_SLOTS,
  localparam int PW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          loop,
  input  logic          stop,
  output logic [PW-1:0] pin_idx,
  output logic          pin_en,
  output logic          code_out,
  output logic [2:0]    field,
  output logic          busy,
  output logic          done
);

  // Slot-counter width must hold the longest field, including the largest
  // row number NUM_PINS/COLS+1.
  localparam int MAX_LEN = max_int(max_int(COLS, NUM_PINS / COLS + 1),
                                   max_int(PRE_SLOTS, max_int(PAUSE_SLOTS, GAP_SLOTS)));
  localparam int LW = $clog2(MAX_LEN + 1);

  scan_state_t state, next_state;
  logic [LW-1:0] slot_cnt, field_len, col_len, row_len;
  logic          stop_latched;
  logic          high_phase, slot_end, field_end;
  logic          frame_end, last_pin, advance;

  scan_slot_timer #(.HALF(HALF)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (state == ST_IDLE),
    .high_phase (high_phase),
    .slot_end   (slot_end)
  );

  // pin_idx only changes at frame boundaries, so col/row are frame-stable.
  assign col_len  = LW'(int'(pin_idx) % COLS + 1);
  assign row_len  = LW'(int'(pin_idx) / COLS + 1);
  assign last_pin = (pin_idx == PW'(NUM_PINS - 1));

  always_comb begin
    field_len = '0;
    case (state)
      ST_PRE:   field_len = LW'(PRE_SLOTS);
      ST_COL:   field_len = col_len;
      ST_PAUSE: field_len = LW'(PAUSE_SLOTS);
      ST_ROW:   field_len = row_len;
      ST_GAP:   field_len = LW'(GAP_SLOTS);
      default:  field_len = '0;
    endcase
  end

  assign field_end = (state != ST_IDLE) && slot_end && (slot_cnt == field_len - 1'b1);

  // Next-state decision. Zero-length PAUSE/GAP are stepped over on the same
  // edge, so no dead cycle appears; frame_end marks the last cycle of a pin.
  always_comb begin
    next_state = state;
    frame_end  = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE:  if (start) next_state = ST_PRE;
      ST_PRE:   if (field_end) next_state = ST_COL;
      ST_COL:   if (field_end) next_state = (PAUSE_SLOTS > 0) ? ST_PAUSE : ST_ROW;
      ST_PAUSE: if (field_end) next_state = ST_ROW;
      ST_ROW: begin
        if (field_end) begin
          if (GAP_SLOTS > 0) next_state = ST_GAP;
          else               frame_end  = 1'b1;
        end
      end
      ST_GAP:   if (field_end) frame_end = 1'b1;
      default:  next_state = ST_IDLE;
    endcase
    if (frame_end) begin
      if (!last_pin && !stop_latched) begin
        advance    = 1'b1;
        next_state = ST_PRE;
      end else if (last_pin && loop && !stop_latched) begin
        next_state = ST_PRE;
      end else begin
        next_state = ST_IDLE;
      end
    end
  end

  // done is decoded from registered state so it lands on the final GAP
  // cycle itself rather than the first idle cycle.
  assign done  = frame_end && last_pin;
  assign field = state;

  function automatic logic level_for(input scan_state_t s, input logic hp);
    case (s)
      ST_PRE:        return 1'b1;
      ST_COL, ST_ROW: return hp;
      default:       return 1'b0;
    endcase
  endfunction

  // Main sequencer register bank. code_out is computed from the state being
  // entered so it stays cycle-aligned with 'field'.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pin_idx      <= '0;
      pin_en       <= 1'b0;
      busy         <= 1'b0;
      code_out     <= 1'b0;
      slot_cnt     <= '0;
      stop_latched <= 1'b0;
    end else begin
      state    <= next_state;
      busy     <= (next_state != ST_IDLE);
      pin_en   <= (next_state != ST_IDLE);
      code_out <= level_for(next_state, high_phase);

      if (state == ST_IDLE || field_end) begin
        slot_cnt <= '0;
      end else if (slot_end) begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (advance) begin
        pin_idx <= pin_idx + 1'b1;
      end else if (state == ST_IDLE || frame_end) begin
        pin_idx <= '0;
      end

      if (next_state == ST_IDLE) begin
        stop_latched <= 1'b0;
      end else if (state != ST_IDLE && stop) begin
        stop_latched <= 1'b1;
      end
    end
  end

endmodule
